// File: rtl/pll_lock_supervisor_pkg.sv
// ============================================================================
// pll_lock_supervisor_pkg : shared widths, defaults and FSM state codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package pll_lock_supervisor_pkg;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned LOSS_W  = 8;
  localparam int unsigned CNT_MAX = 65535;

  localparam int unsigned DEF_HOLD_CYCLES    = 16;
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;
  localparam int unsigned DEF_MAX_RETRIES    = 3;

  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] ST_PLLRST   = 3'd0;
  localparam logic [2:0] ST_WAITLOCK = 3'd1;
  localparam logic [2:0] ST_STABLE   = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

endpackage

`default_nettype wire

// File: rtl/pll_lock_supervisor_if.sv
// ============================================================================
// pll_lock_supervisor_if : PLL-side and system-side control signals
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pll_lock_supervisor_if;
  import pll_lock_supervisor_pkg::*;

  logic              lock;
  logic              relock;
  logic              pll_resetb;
  logic              pll_bypass;
  logic              sys_reset;
  logic              ready;
  logic              fault;
  logic [LOSS_W-1:0] loss_count;

  modport slave (
    input  lock, relock,
    output pll_resetb, pll_bypass, sys_reset, ready, fault, loss_count
  );

  modport master (
    output lock, relock,
    input  pll_resetb, pll_bypass, sys_reset, ready, fault, loss_count
  );

endinterface

`default_nettype wire

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchroniser, asynchronous active-high reset to 0
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic d_i,
  output logic      q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// pll_lock_supervisor : PLL reset sequencing, lock qualification, retry/fault
// Revision: 1.0
// ============================================================================
`default_nettype none

module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  wire logic                referenceclk_i,
  input  wire logic                reset_i,
  pll_lock_supervisor_if.slave     pll_if
);

  if (HOLD_CYCLES > CNT_MAX || STABLE_CYCLES > CNT_MAX || TIMEOUT_CYCLES > CNT_MAX ||
      MAX_RETRIES > CNT_MAX || MAX_RETRIES == 0) begin : g_param_check
    $fatal(1, "pll_lock_supervisor: parameter out of range");
  end

  localparam logic [CNT_W-1:0] C_HOLD    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] C_STABLE  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_MAXRTY  = CNT_W'(MAX_RETRIES);

  logic               lock_s;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   retry_q, retry_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               pll_resetb_q, sys_reset_q, ready_q, fault_q;
  logic               cnt_last;

  sync_2ff u_lock_sync (
    .clk_i (referenceclk_i),
    .rst_i (reset_i),
    .d_i   (pll_if.lock),
    .q_o   (lock_s)
  );

  // A value of 1 (or 0 for a zero-length parameter) marks the final cycle of a count.
  assign cnt_last = (cnt_q <= CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (pll_if.relock && (state_q != ST_FAULT)) begin
      state_d = ST_PLLRST;
      cnt_d   = C_HOLD;
    end else begin
      case (state_q)
        ST_PLLRST: begin
          if (cnt_last) begin
            state_d = ST_WAITLOCK;
            cnt_d   = C_TIMEOUT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_WAITLOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = C_STABLE;
          end else if (cnt_last) begin
            retry_d = retry_q + CNT_W'(1);
            if (retry_d == C_MAXRTY) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_PLLRST;
              cnt_d   = C_HOLD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // A dropout only restarts qualification; it is not a failed attempt.
          if (!lock_s) begin
            state_d = ST_WAITLOCK;
            cnt_d   = C_TIMEOUT;
          end else if (cnt_last) begin
            state_d = ST_RUN;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            if (loss_q != '1) begin
              loss_d = loss_q + LOSS_W'(1);
            end
            state_d = ST_PLLRST;
            cnt_d   = C_HOLD;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_PLLRST;
          cnt_d   = C_HOLD;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_ff @(posedge referenceclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_PLLRST;
      cnt_q        <= C_HOLD;
      retry_q      <= '0;
      loss_q       <= '0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_resetb_q <= !((state_d == ST_PLLRST) || (state_d == ST_FAULT));
      sys_reset_q  <= (state_d != ST_RUN);
      ready_q      <= (state_d == ST_RUN);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign pll_if.pll_resetb = pll_resetb_q;
  assign pll_if.pll_bypass = 1'b0;
  assign pll_if.sys_reset  = sys_reset_q;
  assign pll_if.ready      = ready_q;
  assign pll_if.fault      = fault_q;
  assign pll_if.loss_count = loss_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
// tb_pll_lock_supervisor : directed scenarios with hand-computed cycle timing
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .HOLD_CYCLES    (4),
    .STABLE_CYCLES  (8),
    .TIMEOUT_CYCLES (32),
    .MAX_RETRIES    (2)
  ) dut (
    .referenceclk_i (clk),
    .reset_i        (rst),
    .pll_if         (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Edge k below is the k-th rising edge after reset is released on a falling edge.
  task automatic restart(input logic lock_val);
    @(negedge clk);
    rst = 1'b1;
    bus.lock = lock_val;
    bus.relock = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_rb, exp_rdy;
    bus.lock = 1'b1;
    bus.relock = 1'b0;
    cyc(3);
    n_checks += 6;
    if (bus.pll_resetb !== 1'b0) begin n_fail++; $display("FAIL rst_pll_resetb: got %b want 0", bus.pll_resetb); end
    if (bus.sys_reset !== 1'b1)  begin n_fail++; $display("FAIL rst_sys_reset: got %b want 1", bus.sys_reset); end
    if (bus.ready !== 1'b0)      begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.ready); end
    if (bus.fault !== 1'b0)      begin n_fail++; $display("FAIL rst_fault: got %b want 0", bus.fault); end
    if (bus.pll_bypass !== 1'b0) begin n_fail++; $display("FAIL rst_bypass: got %b want 0", bus.pll_bypass); end
    if (bus.loss_count !== 8'd0) begin n_fail++; $display("FAIL rst_loss: got %0d want 0", bus.loss_count); end
    rst = 1'b0;
    // Hold edges 1-3, WAITLOCK after 4, STABLE after 5, 8 qualified cycles -> RUN after 13.
    for (int k = 1; k <= 14; k++) begin
      cyc(1);
      exp_rb  = (k >= 4);
      exp_rdy = (k >= 13);
      n_checks += 3;
      if (bus.pll_resetb !== exp_rb) begin n_fail++; $display("FAIL lockhigh_resetb k=%0d: got %b want %b", k, bus.pll_resetb, exp_rb); end
      if (bus.ready !== exp_rdy) begin n_fail++; $display("FAIL lockhigh_ready k=%0d: got %b want %b", k, bus.ready, exp_rdy); end
      if (bus.sys_reset !== !exp_rdy) begin n_fail++; $display("FAIL lockhigh_sysrst k=%0d: got %b want %b", k, bus.sys_reset, !exp_rdy); end
    end
  endtask

  task automatic test_relock();
    logic exp_rb, exp_rdy;
    bus.relock = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cyc(1);
      if (k == 1) bus.relock = 1'b0;
      exp_rb  = (k >= 5);
      exp_rdy = (k >= 14);
      n_checks += 2;
      if (bus.pll_resetb !== exp_rb) begin n_fail++; $display("FAIL relock_resetb k=%0d: got %b want %b", k, bus.pll_resetb, exp_rb); end
      if (bus.ready !== exp_rdy) begin n_fail++; $display("FAIL relock_ready k=%0d: got %b want %b", k, bus.ready, exp_rdy); end
    end
    n_checks++;
    if (bus.loss_count !== 8'd0) begin n_fail++; $display("FAIL relock_loss: got %0d want 0", bus.loss_count); end
  endtask

  task automatic test_loss_count();
    logic [7:0] exp_loss;
    bit got;
    for (int i = 1; i <= 300; i++) begin
      bus.lock = 1'b0;
      cyc(2);
      n_checks++;
      if (bus.sys_reset !== 1'b0) begin n_fail++; $display("FAIL loss_sysrst_early i=%0d: got %b want 0", i, bus.sys_reset); end
      cyc(1);
      exp_loss = (i > 255) ? 8'd255 : 8'(i);
      n_checks += 3;
      if (bus.sys_reset !== 1'b1) begin n_fail++; $display("FAIL loss_sysrst i=%0d: got %b want 1", i, bus.sys_reset); end
      if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready i=%0d: got %b want 0", i, bus.ready); end
      if (bus.loss_count !== exp_loss) begin n_fail++; $display("FAIL loss_count i=%0d: got %0d want %0d", i, bus.loss_count, exp_loss); end
      bus.lock = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
        cyc(1);
        if (bus.ready === 1'b1) got = 1'b1;
      end
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL loss_relock_timeout i=%0d: got ready=0 want ready=1 within 40 cycles", i);
        break;
      end
    end
  endtask

  task automatic test_async_reset();
    bus.relock = 1'b1;
    cyc(1);
    bus.relock = 1'b0;
    cyc(1);
    #2 rst = 1'b1;
    #1;
    n_checks += 5;
    if (bus.loss_count !== 8'd0) begin n_fail++; $display("FAIL arst_pllrst_loss: got %0d want 0", bus.loss_count); end
    if (bus.pll_resetb !== 1'b0) begin n_fail++; $display("FAIL arst_pllrst_resetb: got %b want 0", bus.pll_resetb); end
    if (bus.sys_reset !== 1'b1) begin n_fail++; $display("FAIL arst_pllrst_sysrst: got %b want 1", bus.sys_reset); end
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL arst_pllrst_ready: got %b want 0", bus.ready); end
    if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL arst_pllrst_fault: got %b want 0", bus.fault); end
    @(negedge clk);
    rst = 1'b0;
    cyc(8);
    n_checks++;
    if (bus.pll_resetb !== 1'b1) begin n_fail++; $display("FAIL arst_stable_pre: got %b want 1", bus.pll_resetb); end
    #2 rst = 1'b1;
    #1;
    n_checks += 4;
    if (bus.pll_resetb !== 1'b0) begin n_fail++; $display("FAIL arst_stable_resetb: got %b want 0", bus.pll_resetb); end
    if (bus.sys_reset !== 1'b1) begin n_fail++; $display("FAIL arst_stable_sysrst: got %b want 1", bus.sys_reset); end
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL arst_stable_ready: got %b want 0", bus.ready); end
    if (bus.pll_bypass !== 1'b0) begin n_fail++; $display("FAIL arst_stable_bypass: got %b want 0", bus.pll_bypass); end
    @(negedge clk);
  endtask

  task automatic test_glitch();
    logic exp_rb, exp_rdy;
    restart(1'b1);
    // LOCK low across edge 7 makes lock_s low at edge 9 (STABLE count 5): re-enter STABLE at 10, RUN at 18.
    for (int k = 1; k <= 19; k++) begin
      cyc(1);
      exp_rb  = (k >= 4);
      exp_rdy = (k >= 18);
      n_checks += 2;
      if (bus.pll_resetb !== exp_rb) begin n_fail++; $display("FAIL glitch_resetb k=%0d: got %b want %b", k, bus.pll_resetb, exp_rb); end
      if (bus.ready !== exp_rdy) begin n_fail++; $display("FAIL glitch_ready k=%0d: got %b want %b", k, bus.ready, exp_rdy); end
      if (k == 6) bus.lock = 1'b0;
      if (k == 7) bus.lock = 1'b1;
    end
  endtask

  task automatic test_timeout_fault();
    logic exp_rb, exp_flt;
    restart(1'b0);
    // Pulses on edges 1-3 and 36-39, timeouts after 32 high cycles, FAULT from edge 72.
    for (int k = 1; k <= 100; k++) begin
      cyc(1);
      exp_rb  = !((k <= 3) || (k >= 36 && k <= 39) || (k >= 72));
      exp_flt = (k >= 72);
      n_checks += 3;
      if (bus.pll_resetb !== exp_rb) begin n_fail++; $display("FAIL timeout_resetb k=%0d: got %b want %b", k, bus.pll_resetb, exp_rb); end
      if (bus.fault !== exp_flt) begin n_fail++; $display("FAIL timeout_fault k=%0d: got %b want %b", k, bus.fault, exp_flt); end
      if (bus.sys_reset !== 1'b1) begin n_fail++; $display("FAIL timeout_sysrst k=%0d: got %b want 1", k, bus.sys_reset); end
      if (k == 75) bus.lock = 1'b1;
      if (k == 80) bus.relock = 1'b1;
      if (k == 81) bus.relock = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_checks += 2;
    if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL fault_cleared: got %b want 0", bus.fault); end
    if (bus.pll_resetb !== 1'b0) begin n_fail++; $display("FAIL fault_reset_resetb: got %b want 0", bus.pll_resetb); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.lock = 1'b0;
    bus.relock = 1'b0;
    test_reset();
    test_relock();
    test_loss_count();
    test_async_reset();
    test_glitch();
    test_timeout_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
